// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating counter per
//   entry. Predicts fetch-stage direction/target and resolves mispredictions
//   for instructions coming out of execute.
//
//   Parameters
//     XLEN     datapath / PC width
//     ENTRIES  table entries (power of two, 2..256)
//
//   Ports
//     clk, rst         clock, asynchronous active-low reset
//     if_pc            fetch PC to look up
//     pred_taken       predicted taken for if_pc
//     pred_target      predicted next PC for if_pc
//     upd_*            resolved instruction info (valid, pc, kind, outcome,
//                      actual target, prediction carried down the pipe)
//     flush            misprediction, kill younger instructions
//     redirect_pc      correct next PC when flush is high
//
//   Optional feature (macro BP_STATS_EN)
//     stat_lookups     saturating count of resolved branch/jump updates
//     stat_mispredicts saturating count of flush cycles
module branch_predictor #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Table state: valid and counter are reset; tag and target are not.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit;
  logic             actual_taken;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle update to the
  // same entry is not visible until the next cycle.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + PC_STEP);

  assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign actual_taken = upd_is_jump || (upd_is_branch && upd_taken);
  assign flush        = upd_valid &&
                        ((upd_pred_taken != actual_taken) ||
                         (actual_taken && (upd_pred_target != upd_target)));
  assign redirect_pc  = actual_taken ? upd_target : (upd_pc + PC_STEP);

  // Next table contents. Jumps always (re)allocate as strongly taken;
  // a non-control instruction that hits is an alias and is evicted.
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_valid) begin
      if (upd_is_jump) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'b11;
      end else if (upd_is_branch) begin
        if (upd_hit) begin
          if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) begin
              ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
            end
            target_d[upd_idx] = upd_target;
          end else if (ctr_q[upd_idx] != 2'b00) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
          end
        end else if (upd_taken) begin
          valid_d[upd_idx]  = 1'b1;
          tag_d[upd_idx]    = upd_tag;
          target_d[upd_idx] = upd_target;
          ctr_d[upd_idx]    = 2'b10;
        end
      end else if (upd_hit) begin
        valid_d[upd_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Payload storage is not reset; it is only written outside reset so an
  // update overlapping reset leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] mispredicts_q, mispredicts_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    lookups_d     = lookups_q;
    mispredicts_d = mispredicts_q;
    if (upd_valid && (upd_is_branch || upd_is_jump) && (lookups_q != 32'hFFFF_FFFF)) begin
      lookups_d = lookups_q + 32'd1;
    end
    if (flush && (mispredicts_q != 32'hFFFF_FFFF)) begin
      mispredicts_d = mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookups_q     <= 32'd0;
      mispredicts_q <= 32'd0;
    end else begin
      lookups_q     <= lookups_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (XLEN=64, ENTRIES=16).
// Directed scenarios followed by randomized updates/lookups compared
// against a table model kept in plain arrays.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [63:0] if_pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_pred_taken;
  logic [63:0] upd_pred_target;
  logic        flush;
  logic [63:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;
  int          exp_lookups;
  int          exp_mispredicts;
`endif

  int checks;
  int errors;

  // Reference table: one slot per index, tag kept as the PC's upper part.
  bit          m_valid [16];
  longint      m_tag   [16];
  logic [63:0] m_tgt   [16];
  int          m_ctr   [16];

  branch_predictor #(.XLEN(64), .ENTRIES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_branch   (upd_is_branch),
    .upd_is_jump     (upd_is_jump),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int slotOf(input logic [63:0] pc);
    return int'((pc / 64'd4) % 64'd16);
  endfunction

  function automatic longint tagOf(input logic [63:0] pc);
    return longint'(pc / 64'd64);
  endfunction

  function automatic bit modelHit(input logic [63:0] pc);
    return m_valid[slotOf(pc)] && (m_tag[slotOf(pc)] == tagOf(pc));
  endfunction

  task automatic modelLookup(input logic [63:0] pc, output bit t, output logic [63:0] tgt);
    t   = modelHit(pc) && (m_ctr[slotOf(pc)] >= 2);
    tgt = t ? m_tgt[slotOf(pc)] : pc + 64'd4;
  endtask

  function automatic bit actualTaken();
    return upd_is_jump || (upd_is_branch && upd_taken);
  endfunction

  function automatic bit expFlush();
    return upd_valid && ((upd_pred_taken != actualTaken()) ||
                         (actualTaken() && (upd_pred_target != upd_target)));
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
  endtask

  task automatic modelUpdate();
    int  s;
    bit  h;
    s = slotOf(upd_pc);
    h = modelHit(upd_pc);
    if (upd_is_jump) begin
      m_valid[s] = 1'b1; m_tag[s] = tagOf(upd_pc); m_tgt[s] = upd_target; m_ctr[s] = 3;
    end else if (upd_is_branch) begin
      if (h) begin
        if (upd_taken) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = upd_target;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (upd_taken) begin
        m_valid[s] = 1'b1; m_tag[s] = tagOf(upd_pc); m_tgt[s] = upd_target; m_ctr[s] = 2;
      end
    end else if (h) begin
      m_valid[s] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] pc_f, input bit v, input logic [63:0] pc_u,
                               input bit br, input bit jmp, input bit tk,
                               input logic [63:0] tgt, input bit pt, input logic [63:0] ptg);
    if_pc           = pc_f;
    upd_valid       = v;
    upd_pc          = pc_u;
    upd_is_branch   = br;
    upd_is_jump     = jmp;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = pt;
    upd_pred_target = ptg;
  endtask

  // Compares all outputs against the model's pre-edge view.
  task automatic checkOutput(input string tag);
    bit          et;
    logic [63:0] etg;
    #1;
    modelLookup(if_pc, et, etg);
    check({tag, ".pred_taken"},  {63'd0, pred_taken}, {63'd0, et});
    check({tag, ".pred_target"}, pred_target, etg);
    check({tag, ".flush"},       {63'd0, flush}, {63'd0, expFlush()});
    check({tag, ".redirect"},    redirect_pc, actualTaken() ? upd_target : upd_pc + 64'd4);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
`ifdef BP_STATS_EN
      if (upd_valid && (upd_is_branch || upd_is_jump)) exp_lookups++;
      if (expFlush()) exp_mispredicts++;
`endif
      if (upd_valid) modelUpdate();
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] randPc();
    return 64'($urandom_range(0, 255)) * 64'd4;
  endfunction

  initial begin
    bit          lt;
    logic [63:0] ltg;
    int          kind;
    checks = 0;
    errors = 0;
`ifdef BP_STATS_EN
    exp_lookups = 0;
    exp_mispredicts = 0;
`endif
    modelClear();
    rst = 1'b0;
    applyStimulus(64'h100, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput("in_reset");
    @(negedge clk);
    rst = 1'b1;

    // Cold lookup
    checkOutput("cold");
    check("cold.pred_target_const", pred_target, 64'h104);

    // First taken branch mispredicts, then allocates weakly taken
    applyStimulus(64'h100, 1'b1, 64'h100, 1'b1, 1'b0, 1'b1, 64'h80, 1'b0, 64'h104);
    checkOutput("br_alloc");
    check("br_alloc.flush_const", {63'd0, flush}, 64'd1);
    check("br_alloc.redirect_const", redirect_pc, 64'h80);
    tick();
    applyStimulus(64'h100, 1'b1, 64'h100, 1'b1, 1'b0, 1'b1, 64'h80, 1'b1, 64'h80);
    checkOutput("br_strengthen");
    check("br_hit.pred_taken_const", {63'd0, pred_taken}, 64'd1);
    check("br_hit.pred_target_const", pred_target, 64'h80);
    tick();

    // Two not-taken resolutions from strongly taken
    applyStimulus(64'h100, 1'b1, 64'h100, 1'b1, 1'b0, 1'b0, 64'h80, 1'b1, 64'h80);
    checkOutput("nt1");
    check("nt1.redirect_const", redirect_pc, 64'h104);
    tick();
    checkOutput("nt1_after");
    check("nt1_after.pred_taken_const", {63'd0, pred_taken}, 64'd1);
    tick();
    checkOutput("nt2_after");
    check("nt2_after.pred_taken_const", {63'd0, pred_taken}, 64'd0);

    // Aliasing at index 0: jump then a different-tag branch
    applyStimulus(64'h100, 1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 64'h200, 1'b0, 64'h104);
    checkOutput("jump");
    tick();
    applyStimulus(64'h100, 1'b1, 64'h140, 1'b1, 1'b0, 1'b1, 64'h300, 1'b0, 64'h144);
    checkOutput("alias_br");
    tick();
    applyStimulus(64'h100, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    checkOutput("alias_old");
    check("alias_old.pred_target_const", pred_target, 64'h104);
    if_pc = 64'h140;
    checkOutput("alias_new");
    check("alias_new.pred_target_const", pred_target, 64'h300);

    // Same-cycle lookup and update: lookup sees old contents
    applyStimulus(64'h140, 1'b1, 64'h140, 1'b0, 1'b1, 1'b0, 64'h500, 1'b1, 64'h300);
    checkOutput("bypass");
    check("bypass.old_target_const", pred_target, 64'h300);
    tick();
    checkOutput("bypass_after");
    check("bypass_after.new_target_const", pred_target, 64'h500);

    // Non-control instruction hitting an entry evicts it
    applyStimulus(64'h140, 1'b1, 64'h140, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h144);
    checkOutput("evict");
    tick();
    checkOutput("evict_after");

    // Re-allocate, then reset mid-update: immediate miss, update discarded
    applyStimulus(64'h140, 1'b1, 64'h140, 1'b0, 1'b1, 1'b0, 64'h700, 1'b0, 64'h144);
    tick();
    check("realloc.pred_taken_const", {63'd0, pred_taken}, 64'd1);
    rst = 1'b0;
    modelClear();
    applyStimulus(64'h140, 1'b1, 64'h180, 1'b0, 1'b1, 1'b0, 64'h600, 1'b0, 64'h184);
    checkOutput("mid_reset");
    check("mid_reset.pred_taken_const", {63'd0, pred_taken}, 64'd0);
    tick();
    rst = 1'b1;
    applyStimulus(64'h180, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    checkOutput("post_reset");
    check("post_reset.pred_target_const", pred_target, 64'h184);

    // Randomized traffic over a small PC range so entries collide often
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      upd_pc = randPc();
      modelLookup(upd_pc, lt, ltg);
      case ($urandom_range(0, 3))
        0:       ltg = 64'h80;
        1:       ltg = 64'h300;
        2:       ltg = {$urandom, $urandom} & ~64'd3;
        default: ltg = ltg;
      endcase
      applyStimulus(randPc(), ($urandom_range(0, 3) != 0), upd_pc,
                    (kind < 6), (kind == 6 || kind == 7), 1'($urandom_range(0, 1)),
                    (($urandom_range(0, 2) == 0) ? {$urandom, $urandom} & ~64'd3 : ltg),
                    ($urandom_range(0, 4) == 0) ? ~lt : lt, ltg);
      checkOutput($sformatf("rand%0d", n));
      tick();
    end

`ifdef BP_STATS_EN
    check("stat_lookups", {32'd0, stat_lookups}, 64'(exp_lookups));
    check("stat_mispredicts", {32'd0, stat_mispredicts}, 64'(exp_mispredicts));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, number of table entries; power of two, 2..256.
REQ-003 SHALL derive IDX_W = log2(ENTRIES) and TAG_W = XLEN-IDX_W-2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port if_pc  input  XLEN  fetch PC to look up.
REQ-007 SHALL have port pred_taken  output  1  predicted taken for if_pc.
REQ-008 SHALL have port pred_target  output  XLEN  predicted next PC for if_pc.
REQ-009 SHALL have port upd_valid  input  1  resolved instruction presented this cycle.
REQ-010 SHALL have port upd_pc  input  XLEN  PC of the resolved instruction.
REQ-011 SHALL have port upd_is_branch  input  1  resolved instruction is a conditional branch.
REQ-012 SHALL have port upd_is_jump  input  1  resolved instruction is JAL (opcode 1101111).
REQ-013 SHALL have port upd_taken  input  1  actual branch outcome.
REQ-014 SHALL have port upd_target  input  XLEN  actual taken target.
REQ-015 SHALL have port upd_pred_taken  input  1  prediction carried down the pipe with the instruction.
REQ-016 SHALL have port upd_pred_target  input  XLEN  predicted target carried down the pipe.
REQ-017 SHALL have port flush  output  1  mispredict; kill younger instructions.
REQ-018 SHALL have port redirect_pc  output  XLEN  correct next PC when flush=1.

Function
REQ-019 SHALL hold per entry: valid, tag[TAG_W], target[XLEN], ctr[2] (2-bit saturating counter).
REQ-020 SHALL index with pc[IDX_W+1:2] and tag with pc[XLEN-1:IDX_W+2].
REQ-021 SHALL drive pred_taken combinationally = hit && ctr[1], where hit = valid && tag match.
REQ-022 SHALL drive pred_target = stored target when pred_taken, else if_pc+4 (modulo 2^XLEN).
REQ-023 SHALL define actual_taken = upd_is_jump || (upd_is_branch && upd_taken).
REQ-024 SHALL assert flush combinationally when upd_valid && (upd_pred_taken != actual_taken || (actual_taken && upd_pred_target != upd_target)).
REQ-025 SHALL drive redirect_pc = upd_target when actual_taken, else upd_pc+4.
REQ-026 Branch update, hit: ctr increments (taken) or decrements (not taken), saturating at 3 and 0; target written when taken.
REQ-027 Branch update, miss, taken: allocate (overwrite) entry: valid=1, tag, target, ctr=2'b10.
REQ-028 Branch update, miss, not taken: no table change.
REQ-029 Jump update: allocate or overwrite entry with ctr=2'b11 and target=upd_target.
REQ-030 Update of a non-branch, non-jump instruction that hits: clear that entry's valid bit (alias removal).
REQ-031 Lookup and update to the same index in one cycle: lookup sees pre-update contents; no bypass.
REQ-032 upd_valid=0: no table change, flush=0.
REQ-033 Table write takes effect at the rising edge following the update cycle (1-cycle latency).

Reset
REQ-034 rst low SHALL immediately clear all valid bits and ctr fields, independent of clk; tag/target need not be cleared.
REQ-035 During and after reset, pred_taken=0, pred_target=if_pc+4, flush follows REQ-024 from inputs.
REQ-036 Reset asserted mid-update SHALL discard the update.

Configuration
REQ-037 Macro BP_STATS_EN SHALL, when defined, add outputs stat_lookups[32] and stat_mispredicts[32] and their counters.
REQ-038 With BP_STATS_EN: stat_lookups counts cycles with upd_valid && (upd_is_branch||upd_is_jump); stat_mispredicts counts cycles with flush=1; both saturate at 2^32-1 and reset to 0.
REQ-039 Without BP_STATS_EN, neither port nor counter SHALL exist; all other behaviour unchanged.

Verification
REQ-040 After reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-041 Branch at 0x100 taken to 0x80, pred_taken=0 -> flush=1, redirect_pc=0x80; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
REQ-042 Same branch resolved not-taken twice from ctr=2'b11 -> first update leaves prediction taken (ctr=2); second -> pred_taken=0 (ctr=1); first resolution flushes with redirect_pc=0x104.
REQ-043 ENTRIES=16: jump at 0x100 to 0x200, then branch at 0x140 (same index) taken to 0x300 -> 0x100 misses (pred_target=0x104), 0x140 hits with target 0x300.
REQ-044 Simultaneous update and lookup of 0x100 in one cycle -> lookup returns old value; rst pulsed low mid-run -> all lookups miss immediately.
REQ-045 With BP_STATS_EN: 10 branch updates, 3 flushing -> stat_lookups=10, stat_mispredicts=3.
